// File: rtl/invader_missile_pool.sv
// invader_missile_pool: pool of invader missiles with per-slot FSM, cooldown and LFSR-picked shooter column
module invader_missile_pool #(
  parameter int NUM_MISSILES = 3,
  parameter int INVADERS_H = 11,
  parameter int INVADERS_V = 5,
  parameter int OFFSET_H = 32,
  parameter int SPRITE_W = 24,
  parameter int SPRITE_H = 24,
  parameter int STEP = 4,
  parameter int Y_LIMIT = 464,
  parameter int COOLDOWN = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int ID_W = (NUM_MISSILES > 1) ? $clog2(NUM_MISSILES) : 1,
  localparam int CD_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic frame,
  input  logic enable,
  input  logic [9:0] invaders_x,
  input  logic [9:0] invaders_y,
  input  logic [INVADERS_H*INVADERS_V-1:0] alive_mask,
  input  logic hit_valid,
  input  logic [ID_W-1:0] hit_id,
  output logic [10*NUM_MISSILES-1:0] m_x,
  output logic [10*NUM_MISSILES-1:0] m_y,
  output logic [NUM_MISSILES-1:0] m_active,
  output logic fire
);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t st [NUM_MISSILES];
  logic [CD_W-1:0] cd [NUM_MISSILES];
  logic [9:0] x_r [NUM_MISSILES];
  logic [9:0] y_r [NUM_MISSILES];
  logic [15:0] lfsr;
  logic [INVADERS_H-1:0] col_alive;
  int low_row [INVADERS_H];
  int c0, col, tgt;
  logic found, have, do_spawn;
  logic [9:0] sx, sy;
  // Shooter is the bottom-most live invader of the first live column at or after the LFSR column
  always_comb begin
    col_alive = '0;
    for (int c = 0; c < INVADERS_H; c++) begin
      low_row[c] = 0;
      for (int r = 0; r < INVADERS_V; r++)
        if (alive_mask[r*INVADERS_H + c]) begin
          col_alive[c] = 1'b1;
          low_row[c] = r;
        end
    end
    c0 = int'(lfsr % 16'(INVADERS_H));
    found = 1'b0;
    col = 0;
    for (int k = 0; k < INVADERS_H; k++)
      if (!found && col_alive[(c0 + k) % INVADERS_H]) begin
        found = 1'b1;
        col = (c0 + k) % INVADERS_H;
      end
    have = 1'b0;
    tgt = 0;
    for (int i = 0; i < NUM_MISSILES; i++)
      if (!have && st[i] == IDLE && cd[i] == '0) begin
        have = 1'b1;
        tgt = i;
      end
  end
  assign do_spawn = frame && enable && found && have;
  assign sx = invaders_x + 10'(SPRITE_W / 2 + OFFSET_H * col);
  assign sy = invaders_y + 10'(SPRITE_H * (low_row[col] + 1));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= LFSR_SEED;
      fire <= 1'b0;
      for (int i = 0; i < NUM_MISSILES; i++) begin
        st[i] <= IDLE;
        cd[i] <= '0;
        x_r[i] <= '0;
        y_r[i] <= '0;
      end
    end else if (clear) begin
      lfsr <= LFSR_SEED;
      fire <= 1'b0;
      for (int i = 0; i < NUM_MISSILES; i++) begin
        st[i] <= IDLE;
        cd[i] <= '0;
        x_r[i] <= '0;
        y_r[i] <= '0;
      end
    end else begin
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      fire <= do_spawn;
      for (int i = 0; i < NUM_MISSILES; i++) begin
        if (hit_valid && int'(hit_id) == i && st[i] == ACTIVE) begin
          st[i] <= IDLE;
          cd[i] <= CD_W'(COOLDOWN);
        end else if (frame && enable) begin
          if (st[i] == ACTIVE) begin
            if (({1'b0, y_r[i]} + 11'(STEP)) >= 11'(Y_LIMIT)) begin
              st[i] <= IDLE;
              cd[i] <= CD_W'(COOLDOWN);
            end else
              y_r[i] <= y_r[i] + 10'(STEP);
          end else if (do_spawn && tgt == i) begin
            st[i] <= ACTIVE;
            x_r[i] <= sx;
            y_r[i] <= sy;
          end else if (cd[i] != '0)
            cd[i] <= cd[i] - 1'b1;
        end
      end
    end
  end
  for (genvar g = 0; g < NUM_MISSILES; g++) begin : g_pack
    assign m_x[10*g +: 10] = x_r[g];
    assign m_y[10*g +: 10] = y_r[g];
    assign m_active[g] = (st[g] == ACTIVE);
  end
endmodule
